proc_run_ctrl: RTL and testbench

// Synthesizable run-control and trace unit for the pipelined processor; replaces hand-toggled clock/enable stimulus.

---
 rtl/proc_run_ctrl_pkg.sv | 31 +++
 rtl/proc_trace_fifo.sv | 86 ++++++++
 rtl/proc_run_ctrl.sv | 154 +++++++++++++++
 tb/tb_proc_run_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_run_ctrl_pkg.sv
// Shared definitions for the processor run-control unit: command opcodes,
// FSM state encodings and small state-class helpers.
package proc_run_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_HALT  = 2'b00,
    OP_RUN   = 2'b01,
    OP_STEP  = 2'b10,
    OP_RUN_N = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_RST_HOLD = 3'd0,
    ST_HALT     = 3'd1,
    ST_RUN      = 3'd2,
    ST_STEP     = 3'd3,
    ST_RUN_N    = 3'd4,
    ST_BREAK    = 3'd5
  } run_state_e;

  // States in which the core is allowed to advance its PC.
  function automatic logic is_exec_state(input run_state_e s);
    return (s == ST_RUN) || (s == ST_STEP) || (s == ST_RUN_N);
  endfunction

  // States in which PC breakpoints are honoured (STEP never stops).
  function automatic logic is_bp_state(input run_state_e s);
    return (s == ST_RUN) || (s == ST_RUN_N);
  endfunction

endpackage

// File: rtl/proc_trace_fifo.sv
// Circular first-word-fall-through trace buffer; a push into a full buffer
// without a simultaneous pop drops the oldest entry and sets a sticky flag.
module proc_trace_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             overflow_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic empty;
  logic full;
  logic pop_ok;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == (PTR_W+1)'(DEPTH));
  assign pop_ok = pop_i && !empty;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (push_i) begin
      wr_d = wr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_d = rd_q + PTR_W'(1);
    end
    if (push_i && !pop_ok) begin
      if (full) begin
        // Write slot coincides with the oldest entry: advance past it.
        rd_d  = rd_q + PTR_W'(1);
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + (PTR_W+1)'(1);
      end
    end else if (!push_i && pop_ok) begin
      cnt_d = cnt_q - (PTR_W+1)'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the count and pointers
  // decide what is valid, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

  assign valid_o    = !empty;
  assign data_o     = mem_q[rd_q];
  assign overflow_o = ovf_q;

endmodule

// File: rtl/proc_run_ctrl.sv
// Run-control and trace unit for the pipelined processor: sequences core
// reset, gates pc_enable per debug command, stops on PC breakpoints, traces.
module proc_run_ctrl
  import proc_run_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_BP      = 2,
  parameter int TRACE_DEPTH = 16,
  parameter int CNT_W       = 16,
  parameter int RST_CYCLES  = 2
) (
  input  logic                     p_clk,
  input  logic                     p_rst_s,
  input  logic                     cmd_valid,
  input  logic [1:0]               cmd_op,
  input  logic [CNT_W-1:0]         cmd_count,
  output logic                     cmd_ready,
  input  logic [NUM_BP-1:0]        bp_en,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0]        rom_addrs,
  input  logic [DATA_W-1:0]        instruction,
  output logic                     core_rst,
  output logic                     pc_enable,
  output logic [2:0]               state,
  output logic [NUM_BP-1:0]        bp_hit,
  output logic [31:0]              cycle_cnt,
  input  logic                     trc_rd,
  output logic                     trc_valid,
  output logic [ADDR_W-1:0]        trc_addr,
  output logic [DATA_W-1:0]        trc_instr,
  output logic                     trc_overflow
);

  localparam int RST_CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_CW-1:0] RST_LAST = RST_CW'(RST_CYCLES - 1);

  run_state_e          state_q, state_d;
  logic [CNT_W-1:0]    run_cnt_q, run_cnt_d;
  logic [RST_CW-1:0]   rst_cnt_q, rst_cnt_d;
  logic                skip_q, skip_d;
  logic [NUM_BP-1:0]   bp_hit_q, bp_hit_d;
  logic [31:0]         cycle_cnt_q, cycle_cnt_d;

  logic [NUM_BP-1:0]   bp_match;
  logic                bp_stop;
  logic                cmd_acc;

  always_comb begin
    bp_match = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      bp_match[i] = bp_en[i] && (rom_addrs == bp_addr[i*ADDR_W +: ADDR_W]);
    end
  end

  // The first cycle after a resume from BREAK is still sitting on the
  // breakpoint PC; skip_q lets that one instruction through.
  assign bp_stop   = is_bp_state(state_q) && !skip_q && (|bp_match);
  assign pc_enable = is_exec_state(state_q) && !bp_stop;
  assign cmd_ready = (state_q != ST_RST_HOLD);
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign core_rst  = (state_q == ST_RST_HOLD);
  assign state     = state_q;
  assign bp_hit    = bp_hit_q;
  assign cycle_cnt = cycle_cnt_q;

  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    rst_cnt_d = rst_cnt_q;
    skip_d    = 1'b0;

    unique case (state_q)
      ST_RST_HOLD: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = ST_HALT;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_CW'(1);
        end
      end
      ST_RUN: begin
        if (bp_stop) state_d = ST_BREAK;
      end
      ST_STEP: begin
        state_d = ST_HALT;
      end
      ST_RUN_N: begin
        if (bp_stop) begin
          state_d = ST_BREAK;
        end else begin
          run_cnt_d = run_cnt_q - CNT_W'(1);
          if (run_cnt_q == CNT_W'(1)) state_d = ST_HALT;
        end
      end
      default: ;
    endcase

    // A new command overrides whatever the current state would do next.
    if (cmd_acc) begin
      unique case (cmd_op_e'(cmd_op))
        OP_HALT: state_d = ST_HALT;
        OP_RUN:  state_d = ST_RUN;
        OP_STEP: state_d = ST_STEP;
        OP_RUN_N: begin
          run_cnt_d = cmd_count;
          state_d   = (cmd_count == '0) ? ST_HALT : ST_RUN_N;
        end
      endcase
      skip_d = (state_q == ST_BREAK) &&
               ((state_d == ST_RUN) || (state_d == ST_RUN_N));
    end
  end

  always_comb begin
    bp_hit_d    = (cmd_acc ? '0 : bp_hit_q) | (bp_stop ? bp_match : '0);
    cycle_cnt_d = cycle_cnt_q;
    if (pc_enable && (cycle_cnt_q != '1)) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge p_clk) begin
    if (p_rst_s) begin
      state_q     <= ST_RST_HOLD;
      run_cnt_q   <= '0;
      rst_cnt_q   <= '0;
      skip_q      <= 1'b0;
      bp_hit_q    <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      rst_cnt_q   <= rst_cnt_d;
      skip_q      <= skip_d;
      bp_hit_q    <= bp_hit_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  proc_trace_fifo #(
    .WIDTH(ADDR_W + DATA_W),
    .DEPTH(TRACE_DEPTH)
  ) u_trace (
    .clk_i      (p_clk),
    .srst_i     (p_rst_s),
    .push_i     (pc_enable),
    .data_i     ({rom_addrs, instruction}),
    .pop_i      (trc_rd),
    .valid_o    (trc_valid),
    .data_o     ({trc_addr, trc_instr}),
    .overflow_o (trc_overflow)
  );

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Self-checking bench for proc_run_ctrl: directed scenarios followed by
// randomized commands, all compared against a behavioural model.
module tb_proc_run_ctrl;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int NUM_BP      = 2;
  localparam int TRACE_DEPTH = 16;
  localparam int CNT_W       = 16;
  localparam int RST_CYCLES  = 2;

  logic                     p_clk = 1'b0;
  logic                     p_rst_s;
  logic                     cmd_valid;
  logic [1:0]               cmd_op;
  logic [CNT_W-1:0]         cmd_count;
  logic                     cmd_ready;
  logic [NUM_BP-1:0]        bp_en;
  logic [NUM_BP*ADDR_W-1:0] bp_addr;
  logic [ADDR_W-1:0]        rom_addrs;
  logic [DATA_W-1:0]        instruction;
  logic                     core_rst;
  logic                     pc_enable;
  logic [2:0]               state;
  logic [NUM_BP-1:0]        bp_hit;
  logic [31:0]              cycle_cnt;
  logic                     trc_rd;
  logic                     trc_valid;
  logic [ADDR_W-1:0]        trc_addr;
  logic [DATA_W-1:0]        trc_instr;
  logic                     trc_overflow;

  always #5 p_clk = ~p_clk;

  proc_run_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_BP(NUM_BP),
    .TRACE_DEPTH(TRACE_DEPTH), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .p_clk(p_clk), .p_rst_s(p_rst_s),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_ready(cmd_ready),
    .bp_en(bp_en), .bp_addr(bp_addr), .rom_addrs(rom_addrs), .instruction(instruction),
    .core_rst(core_rst), .pc_enable(pc_enable), .state(state), .bp_hit(bp_hit),
    .cycle_cnt(cycle_cnt), .trc_rd(trc_rd), .trc_valid(trc_valid), .trc_addr(trc_addr),
    .trc_instr(trc_instr), .trc_overflow(trc_overflow)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_RST, M_HALT, M_RUN, M_STEP, M_RUNN, M_BREAK} mode_t;

  mode_t             mode;
  int                hold;
  int unsigned       remaining;
  bit                skip;
  logic [NUM_BP-1:0] m_hit;
  logic [31:0]       m_cyc;
  logic [63:0]       m_trace [$];
  bit                m_ovf;
  logic [NUM_BP-1:0] m_match;
  bit                m_stop;
  bit                m_pc_en;

  bit auto_pc = 1'b1;
  int unsigned pulses = 0;
  int unsigned rst_seen = 0;

  function automatic logic [2:0] mode_code(input mode_t m);
    case (m)
      M_RST:   return 3'd0;
      M_HALT:  return 3'd1;
      M_RUN:   return 3'd2;
      M_STEP:  return 3'd3;
      M_RUNN:  return 3'd4;
      default: return 3'd5;
    endcase
  endfunction

  function automatic void model_reset();
    mode = M_RST; hold = 0; remaining = 0; skip = 1'b0;
    m_hit = '0; m_cyc = '0; m_trace.delete(); m_ovf = 1'b0;
  endfunction

  function automatic void model_comb();
    m_match = '0;
    for (int i = 0; i < NUM_BP; i++)
      if (bp_en[i] && rom_addrs == bp_addr[i*ADDR_W +: ADDR_W]) m_match[i] = 1'b1;
    m_stop  = (mode == M_RUN || mode == M_RUNN) && !skip && (m_match != '0);
    m_pc_en = (mode == M_RUN || mode == M_STEP || mode == M_RUNN) && !m_stop;
  endfunction

  function automatic void model_update();
    bit    acc;
    bit    nskip;
    mode_t old;
    if (p_rst_s) begin
      model_reset();
      return;
    end
    acc = cmd_valid && (mode != M_RST);
    if (trc_rd && m_trace.size() > 0) void'(m_trace.pop_front());
    if (m_pc_en) m_trace.push_back({rom_addrs, instruction});
    if (m_trace.size() > TRACE_DEPTH) begin
      void'(m_trace.pop_front());
      m_ovf = 1'b1;
    end
    if (m_pc_en && m_cyc != 32'hFFFF_FFFF) m_cyc++;
    if (acc) m_hit = '0;
    if (m_stop) m_hit = m_hit | m_match;
    nskip = 1'b0;
    old = mode;
    if (mode == M_RST) begin
      hold++;
      if (hold >= RST_CYCLES) mode = M_HALT;
    end else if (acc) begin
      case (cmd_op)
        2'b00: mode = M_HALT;
        2'b01: mode = M_RUN;
        2'b10: mode = M_STEP;
        default: begin
          remaining = cmd_count;
          mode = (cmd_count == 0) ? M_HALT : M_RUNN;
        end
      endcase
      nskip = (old == M_BREAK) && (mode == M_RUN || mode == M_RUNN);
    end else begin
      case (mode)
        M_RUN:  if (m_stop) mode = M_BREAK;
        M_STEP: mode = M_HALT;
        M_RUNN: begin
          if (m_stop) mode = M_BREAK;
          else begin
            remaining--;
            if (remaining == 0) mode = M_HALT;
          end
        end
        default: ;
      endcase
    end
    skip = nskip;
  endfunction

  // One clock: compare all outputs mid-cycle, then advance model with the edge.
  task automatic tick();
    bit en;
    #2;
    model_comb();
    en = m_pc_en;
    check("state", 64'(state), 64'(mode_code(mode)));
    check("core_rst", 64'(core_rst), 64'(mode == M_RST));
    check("cmd_ready", 64'(cmd_ready), 64'(mode != M_RST));
    check("pc_enable", 64'(pc_enable), 64'(m_pc_en));
    check("bp_hit", 64'(bp_hit), 64'(m_hit));
    check("cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
    check("trc_valid", 64'(trc_valid), 64'(m_trace.size() > 0));
    check("trc_overflow", 64'(trc_overflow), 64'(m_ovf));
    if (m_trace.size() > 0) begin
      check("trc_addr", 64'(trc_addr), 64'(m_trace[0][63:32]));
      check("trc_instr", 64'(trc_instr), 64'(m_trace[0][31:0]));
    end
    if (pc_enable === 1'b1) pulses++;
    if (core_rst === 1'b1) rst_seen++;
    @(posedge p_clk);
    model_update();
    #1;
    if (auto_pc && en) rom_addrs = rom_addrs + 32'd4;
    instruction = $urandom;
  endtask

  task automatic send(input logic [1:0] op, input int unsigned cnt);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = CNT_W'(cnt);
    tick();
    cmd_valid = 1'b0;
  endtask

  int unsigned pc_start;
  int unsigned guard;

  initial begin
    p_rst_s = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_count = '0;
    bp_en = '0; bp_addr = '0; rom_addrs = '0; instruction = '0; trc_rd = 1'b0;
    @(posedge p_clk);
    #1;
    model_reset();

    // Reset for three cycles total, then release and count held-reset cycles.
    repeat (2) tick();
    p_rst_s = 1'b0;
    rst_seen = 0;
    repeat (4) tick();
    check("rst_hold_cycles", 64'(rst_seen), 64'(RST_CYCLES));
    check("halt_after_rst", 64'(state), 64'(3'd1));

    // Three single steps from PC 0.
    rom_addrs = '0;
    pulses = 0;
    repeat (3) begin
      send(2'b10, 0);
      repeat (2) tick();
    end
    check("step_pulses", 64'(pulses), 64'd3);
    check("step_cycle_cnt", 64'(cycle_cnt), 64'd3);
    trc_rd = 1'b1;
    repeat (3) tick();
    trc_rd = 1'b0;
    check("step_trace_drained", 64'(trc_valid), 64'd0);

    // RUN_N 5, then RUN_N 0.
    pulses = 0;
    send(2'b11, 5);
    repeat (8) tick();
    check("run_n5_pulses", 64'(pulses), 64'd5);
    pulses = 0;
    send(2'b11, 0);
    repeat (3) tick();
    check("run_n0_pulses", 64'(pulses), 64'd0);
    check("run_n0_state", 64'(state), 64'(3'd1));

    // Breakpoint at 0x10 while running from PC 0, then resume past it.
    rom_addrs = '0;
    bp_addr[0 +: ADDR_W] = 32'h10;
    bp_en = 2'b01;
    send(2'b01, 0);
    guard = 0;
    while (mode != M_BREAK && guard < 20) begin
      tick();
      guard++;
    end
    check("bp_reached", 64'(mode == M_BREAK), 64'd1);
    tick();
    check("bp_state", 64'(state), 64'(3'd5));
    check("bp_hit_set", 64'(bp_hit), 64'd1);
    send(2'b01, 0);
    repeat (3) tick();
    check("bp_hit_clr", 64'(bp_hit), 64'd0);
    check("resume_state", 64'(state), 64'(3'd2));
    send(2'b00, 0);
    bp_en = '0;
    trc_rd = 1'b1;
    repeat (20) tick();
    trc_rd = 1'b0;

    // Overflow: 20 traced cycles with no pops, oldest four lost.
    pc_start = rom_addrs;
    send(2'b11, 20);
    repeat (22) tick();
    check("ovf_set", 64'(trc_overflow), 64'd1);
    check("ovf_first_pop", 64'(trc_addr), 64'(pc_start + 16));

    // Reset asserted mid-run.
    send(2'b01, 0);
    repeat (3) tick();
    p_rst_s = 1'b1;
    tick();
    check("midrst_pc_enable", 64'(pc_enable), 64'd0);
    check("midrst_core_rst", 64'(core_rst), 64'd1);
    check("midrst_trc_valid", 64'(trc_valid), 64'd0);
    check("midrst_cycle_cnt", 64'(cycle_cnt), 64'd0);
    p_rst_s = 1'b0;
    repeat (3) tick();

    // Fill exactly, then push and pop together while full.
    send(2'b11, 16);
    repeat (18) tick();
    check("full_no_ovf", 64'(trc_overflow), 64'd0);
    send(2'b11, 4);
    trc_rd = 1'b1;
    repeat (4) tick();
    trc_rd = 1'b0;
    repeat (2) tick();
    check("full_pushpop_no_ovf", 64'(trc_overflow), 64'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      cmd_valid = ($urandom % 6) == 0;
      cmd_op    = 2'($urandom);
      cmd_count = CNT_W'($urandom % 8);
      trc_rd    = ($urandom % 3) == 0;
      p_rst_s   = ($urandom % 300) == 0;
      if ($urandom % 50 == 0) begin
        bp_en = NUM_BP'($urandom);
        for (int i = 0; i < NUM_BP; i++) bp_addr[i*ADDR_W +: ADDR_W] = ($urandom % 16) * 4;
      end
      if ($urandom % 20 == 0) rom_addrs = ($urandom % 16) * 4;
      tick();
    end
    p_rst_s = 1'b0;
    cmd_valid = 1'b0;
    trc_rd = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
